// File: rtl/multicycle_ctrl_unit_if.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl_unit_if
//   Bundles every signal between the multicycle control unit and its datapath
//   and memory. Clock and reset stay outside as plain module ports.
//
//   master : the control unit (consumes status, drives control)
//   slave  : the datapath / memory side (drives status, consumes control)
//
//   Status  : run, instruct, flags {v,c,n,z}, mem_ready
//   Control : ir_load, pc_write, pc_sel, mem_req, mem_we, addr_sel, rf_write,
//             rf_wsel, alu_op, alu_src_imm, flags_load, state_o, trap
// -----------------------------------------------------------------------------
interface multicycle_ctrl_unit_if #(
  parameter int INSTRUCTION_WIDTH = 16
) ();

  // Status into the controller
  logic                         run;
  logic [INSTRUCTION_WIDTH-1:0] instruct;
  logic [3:0]                   flags;
  logic                         mem_ready;

  // Control out of the controller
  logic                         ir_load;
  logic                         pc_write;
  logic [1:0]                   pc_sel;
  logic                         mem_req;
  logic                         mem_we;
  logic                         addr_sel;
  logic                         rf_write;
  logic [1:0]                   rf_wsel;
  logic [3:0]                   alu_op;
  logic                         alu_src_imm;
  logic                         flags_load;
  logic [2:0]                   state_o;
  logic                         trap;

  modport master (
    input  run, instruct, flags, mem_ready,
    output ir_load, pc_write, pc_sel, mem_req, mem_we, addr_sel, rf_write,
           rf_wsel, alu_op, alu_src_imm, flags_load, state_o, trap
  );

  modport slave (
    output run, instruct, flags, mem_ready,
    input  ir_load, pc_write, pc_sel, mem_req, mem_we, addr_sel, rf_write,
           rf_wsel, alu_op, alu_src_imm, flags_load, state_o, trap
  );

endinterface : multicycle_ctrl_unit_if

// File: rtl/multicycle_ctrl_unit.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl_unit
//   Multicycle control FSM for the 16-op ISA. Sequences
//   IDLE -> FETCH -> DECODE -> EXEC -> MEM -> WB and drives the datapath
//   controls combinationally from the current state and the latched IR.
//   Adds run gating, a memory ready/wait handshake with watchdog, branch
//   condition evaluation, and a sticky trap for illegal opcodes and timeouts.
//
// Ports
//   clk     : rising-edge clock
//   resetn  : asynchronous active-low reset (returns to IDLE, counter cleared)
//   bus     : multicycle_ctrl_unit_if.master (status in, control out)
//
// Opcode map (low 4 bits of the opcode field)
//   0 LI   1 ADDI  2 LW   3 SW   4..11 ALU (ADD..SRA, alu_op = opcode)
//   12 LINK  13 JMP  14 JPR  15 BRH. Any opcode >= 16 is illegal.
// -----------------------------------------------------------------------------
module multicycle_ctrl_unit #(
  parameter int INSTRUCTION_WIDTH = 16,
  parameter int OPCODE_LSB        = 0,
  parameter int OPCODE_WIDTH      = 4,
  parameter int COND_LSB          = 4,
  parameter int MEM_TIMEOUT       = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  multicycle_ctrl_unit_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd7
  } state_e;

  localparam logic [3:0] OP_LI   = 4'd0;
  localparam logic [3:0] OP_ADDI = 4'd1;
  localparam logic [3:0] OP_LW   = 4'd2;
  localparam logic [3:0] OP_SW   = 4'd3;
  localparam logic [3:0] OP_ADD  = 4'd4;
  localparam logic [3:0] OP_SRA  = 4'd11;
  localparam logic [3:0] OP_LINK = 4'd12;
  localparam logic [3:0] OP_JMP  = 4'd13;
  localparam logic [3:0] OP_JPR  = 4'd14;
  localparam logic [3:0] OP_BRH  = 4'd15;

  localparam logic [3:0] ALU_ADD = 4'd4;

  localparam logic [1:0] PC_INC = 2'd0;
  localparam logic [1:0] PC_IMM = 2'd1;
  localparam logic [1:0] PC_REG = 2'd2;

  localparam logic [1:0] WSEL_ALU  = 2'd0;
  localparam logic [1:0] WSEL_MEM  = 2'd1;
  localparam logic [1:0] WSEL_IMM  = 2'd2;
  localparam logic [1:0] WSEL_LINK = 2'd3;

  // The counter only has to hold MEM_TIMEOUT-1: the wait cycle that would
  // reach MEM_TIMEOUT is the one that raises the trap.
  localparam int              CNT_W     = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam bit              WDOG_EN   = (MEM_TIMEOUT > 0);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(WDOG_EN ? MEM_TIMEOUT - 1 : 0);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [OPCODE_WIDTH-1:0] opcode;
  logic [3:0]              op4;
  logic                    op_illegal;
  logic                    is_alu;
  logic [1:0]              cond;
  logic                    br_taken;
  logic                    wait_expired;
  logic [3:0]              alu_op_sel;
  logic                    alu_imm_sel;
  logic                    unused_bits;

  // ---------------------------------------------------------------------------
  // Instruction field decode
  // ---------------------------------------------------------------------------
  assign opcode = bus.instruct[OPCODE_LSB +: OPCODE_WIDTH];
  assign op4    = opcode[3:0];
  assign cond   = bus.instruct[COND_LSB +: 2];
  assign is_alu = (op4 >= OP_ADD) && (op4 <= OP_SRA);

  // Only a field wider than four bits can encode an opcode >= 16.
  if (OPCODE_WIDTH > 4) begin : g_wide_opcode
    assign op_illegal = |opcode[OPCODE_WIDTH-1:4];
  end else begin : g_narrow_opcode
    assign op_illegal = 1'b0;
  end

  // Carry flag and the remaining instruction bits belong to the datapath.
  assign unused_bits = ^{bus.flags[2], bus.instruct};

  // Branch condition on flags {v,c,n,z}.
  always_comb begin
    case (cond)
      2'd0:    br_taken = 1'b1;
      2'd1:    br_taken = bus.flags[0];
      2'd2:    br_taken = ~bus.flags[0];
      default: br_taken = bus.flags[1] ^ bus.flags[3];
    endcase
  end

  // ALU setup shared by EXEC, MEM and WB so the operands stay stable for
  // the whole instruction.
  always_comb begin
    alu_op_sel  = 4'd0;
    alu_imm_sel = 1'b0;
    if (op4 == OP_ADDI || op4 == OP_LW || op4 == OP_SW) begin
      alu_op_sel  = ALU_ADD;
      alu_imm_sel = 1'b1;
    end else if (is_alu) begin
      alu_op_sel  = op4;
    end
  end

  assign wait_expired = WDOG_EN && (cnt_q == CNT_LIMIT);

  // ---------------------------------------------------------------------------
  // State and watchdog registers
  // ---------------------------------------------------------------------------
  // NOTE: reset is asynchronous so control outputs (notably mem_req) fall
  // the moment resetn drops, without waiting for a clock edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output gets a default first, so no path infers a latch.
    state_d         = state_q;
    cnt_d           = '0;
    bus.ir_load     = 1'b0;
    bus.pc_write    = 1'b0;
    bus.pc_sel      = PC_INC;
    bus.mem_req     = 1'b0;
    bus.mem_we      = 1'b0;
    bus.addr_sel    = 1'b0;
    bus.rf_write    = 1'b0;
    bus.rf_wsel     = WSEL_ALU;
    bus.alu_op      = 4'd0;
    bus.alu_src_imm = 1'b0;
    bus.flags_load  = 1'b0;
    bus.trap        = 1'b0;
    bus.state_o     = state_q;

    case (state_q)
      S_IDLE: begin
        if (bus.run) state_d = S_FETCH;
      end

      S_FETCH: begin
        bus.mem_req = 1'b1;
        if (bus.mem_ready) begin
          bus.ir_load  = 1'b1;
          bus.pc_write = 1'b1;
          state_d      = S_DECODE;
        end else if (wait_expired) begin
          state_d = S_TRAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DECODE: begin
        if (op_illegal)         state_d = S_TRAP;
        else if (op4 == OP_LI)  state_d = S_WB;
        else                    state_d = S_EXEC;
      end

      S_EXEC: begin
        bus.alu_op      = alu_op_sel;
        bus.alu_src_imm = alu_imm_sel;
        state_d         = S_FETCH;
        if (is_alu) begin
          bus.flags_load = 1'b1;
          state_d        = S_WB;
        end else begin
          case (op4)
            OP_ADDI: state_d = S_WB;
            OP_LW,
            OP_SW:   state_d = S_MEM;
            OP_LINK: begin
              bus.rf_write = 1'b1;
              bus.rf_wsel  = WSEL_LINK;
            end
            OP_JMP: begin
              bus.pc_write = 1'b1;
              bus.pc_sel   = PC_IMM;
            end
            OP_JPR: begin
              bus.pc_write = 1'b1;
              bus.pc_sel   = PC_REG;
            end
            OP_BRH: begin
              bus.pc_write = br_taken;
              bus.pc_sel   = br_taken ? PC_IMM : PC_INC;
            end
            default: ;
          endcase
        end
      end

      S_MEM: begin
        bus.mem_req     = 1'b1;
        bus.addr_sel    = 1'b1;
        bus.mem_we      = (op4 == OP_SW);
        bus.alu_op      = alu_op_sel;
        bus.alu_src_imm = alu_imm_sel;
        if (bus.mem_ready) begin
          state_d = (op4 == OP_SW) ? S_FETCH : S_WB;
        end else if (wait_expired) begin
          state_d = S_TRAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_WB: begin
        bus.rf_write    = 1'b1;
        bus.alu_op      = alu_op_sel;
        bus.alu_src_imm = alu_imm_sel;
        if (op4 == OP_LI)      bus.rf_wsel = WSEL_IMM;
        else if (op4 == OP_LW) bus.rf_wsel = WSEL_MEM;
        else                   bus.rf_wsel = WSEL_ALU;
        state_d = S_FETCH;
      end

      S_TRAP: begin
        bus.trap = 1'b1;
      end

      // Unused encoding: treat as a fault and park in TRAP.
      default: state_d = S_TRAP;
    endcase
  end

endmodule : multicycle_ctrl_unit

// File: tb/tb_multicycle_ctrl_unit.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl_unit
//   Self-checking bench for multicycle_ctrl_unit. Two instances:
//     dut_a : default parameters, directed plus random instruction stream
//     dut_b : OPCODE_WIDTH=5, COND_LSB=5, MEM_TIMEOUT=4 for watchdog,
//             illegal-opcode and reset cases
//   Expected behaviour comes from a per-instruction trace generator that
//   lists, cycle by cycle, the phase the ISA rules prescribe and the controls
//   asserted there.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl_unit;

  localparam int IW = 16;

  localparam logic [3:0] OP_LI   = 4'd0;
  localparam logic [3:0] OP_ADDI = 4'd1;
  localparam logic [3:0] OP_LW   = 4'd2;
  localparam logic [3:0] OP_SW   = 4'd3;
  localparam logic [3:0] OP_ADD  = 4'd4;
  localparam logic [3:0] OP_SRA  = 4'd11;
  localparam logic [3:0] OP_LINK = 4'd12;
  localparam logic [3:0] OP_JMP  = 4'd13;
  localparam logic [3:0] OP_JPR  = 4'd14;
  localparam logic [3:0] OP_BRH  = 4'd15;

  typedef struct packed {
    logic [2:0] state;
    logic       trap;
    logic       ir_load;
    logic       pc_write;
    logic [1:0] pc_sel;
    logic       mem_req;
    logic       mem_we;
    logic       addr_sel;
    logic       rf_write;
    logic [1:0] rf_wsel;
    logic [3:0] alu_op;
    logic       alu_src_imm;
    logic       flags_load;
  } obs_t;

  // ready: 0/1 drive mem_ready, 2 = don't care (randomised)
  typedef struct {
    obs_t exp;
    int   ready;
  } step_t;

  step_t plan[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  logic clk = 1'b0;
  logic resetn_a;
  logic resetn_b;

  always #5 clk = ~clk;

  multicycle_ctrl_unit_if #(.INSTRUCTION_WIDTH(IW)) bus_a ();
  multicycle_ctrl_unit_if #(.INSTRUCTION_WIDTH(IW)) bus_b ();

  multicycle_ctrl_unit #(
    .INSTRUCTION_WIDTH(IW), .OPCODE_LSB(0), .OPCODE_WIDTH(4),
    .COND_LSB(4), .MEM_TIMEOUT(16)
  ) dut_a (
    .clk(clk), .resetn(resetn_a), .bus(bus_a)
  );

  multicycle_ctrl_unit #(
    .INSTRUCTION_WIDTH(IW), .OPCODE_LSB(0), .OPCODE_WIDTH(5),
    .COND_LSB(5), .MEM_TIMEOUT(4)
  ) dut_b (
    .clk(clk), .resetn(resetn_b), .bus(bus_b)
  );

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  function automatic obs_t sample(input int sel);
    obs_t o;
    if (sel == 0)
      o = {bus_a.state_o, bus_a.trap, bus_a.ir_load, bus_a.pc_write, bus_a.pc_sel,
           bus_a.mem_req, bus_a.mem_we, bus_a.addr_sel, bus_a.rf_write, bus_a.rf_wsel,
           bus_a.alu_op, bus_a.alu_src_imm, bus_a.flags_load};
    else
      o = {bus_b.state_o, bus_b.trap, bus_b.ir_load, bus_b.pc_write, bus_b.pc_sel,
           bus_b.mem_req, bus_b.mem_we, bus_b.addr_sel, bus_b.rf_write, bus_b.rf_wsel,
           bus_b.alu_op, bus_b.alu_src_imm, bus_b.flags_load};
    return o;
  endfunction

  function automatic obs_t base(input logic [2:0] st);
    obs_t o = '0;
    o.state = st;
    return o;
  endfunction

  function automatic void push(input obs_t o, input int ready);
    step_t s;
    s.exp   = o;
    s.ready = ready;
    plan.push_back(s);
  endfunction

  task automatic check(input string tag, input obs_t got, input obs_t exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %p expected %p", tag, got, exp);
    end
  endtask

  // Expected cycle trace of one instruction, starting at its FETCH.
  function automatic void build_plan(input logic [3:0] op, input logic [1:0] cond,
                                     input logic [3:0] fl, input int fwait, input int mwait);
    obs_t       o;
    logic [3:0] aop;
    logic       aimm;
    logic       taken;
    logic       alu;
    alu  = (op >= OP_ADD) && (op <= OP_SRA);
    aop  = 4'd0;
    aimm = 1'b0;
    if (op == OP_ADDI || op == OP_LW || op == OP_SW) begin
      aop  = 4'd4;
      aimm = 1'b1;
    end else if (alu) begin
      aop = op;
    end
    case (cond)
      2'd0:    taken = 1'b1;
      2'd1:    taken = fl[0];
      2'd2:    taken = !fl[0];
      default: taken = fl[1] ^ fl[3];
    endcase

    // FETCH: waits, then the completing cycle
    for (int i = 0; i < fwait; i++) begin
      o = base(3'd1); o.mem_req = 1'b1; push(o, 0);
    end
    o = base(3'd1); o.mem_req = 1'b1; o.ir_load = 1'b1; o.pc_write = 1'b1; push(o, 1);
    // DECODE
    push(base(3'd2), 2);

    if (op == OP_LI) begin
      o = base(3'd5); o.rf_write = 1'b1; o.rf_wsel = 2'd2; push(o, 2);
      return;
    end

    // EXEC
    o = base(3'd3); o.alu_op = aop; o.alu_src_imm = aimm;
    if (alu) o.flags_load = 1'b1;
    if (op == OP_LINK) begin o.rf_write = 1'b1; o.rf_wsel = 2'd3; end
    if (op == OP_JMP)  begin o.pc_write = 1'b1; o.pc_sel = 2'd1; end
    if (op == OP_JPR)  begin o.pc_write = 1'b1; o.pc_sel = 2'd2; end
    if (op == OP_BRH && taken) begin o.pc_write = 1'b1; o.pc_sel = 2'd1; end
    push(o, 2);

    // MEM
    if (op == OP_LW || op == OP_SW) begin
      o = base(3'd4); o.mem_req = 1'b1; o.addr_sel = 1'b1; o.mem_we = (op == OP_SW);
      o.alu_op = aop; o.alu_src_imm = aimm;
      for (int i = 0; i < mwait; i++) push(o, 0);
      push(o, 1);
    end

    // WB
    if (op == OP_ADDI || op == OP_LW || alu) begin
      o = base(3'd5); o.rf_write = 1'b1; o.rf_wsel = (op == OP_LW) ? 2'd1 : 2'd0;
      o.alu_op = aop; o.alu_src_imm = aimm;
      push(o, 2);
    end
  endfunction

  // Play the queued trace against one DUT, one check per cycle.
  task automatic run_plan(input int sel, input string name,
                          input logic [IW-1:0] instr, input logic [3:0] fl);
    step_t s;
    logic  rdy;
    while (plan.size() > 0) begin
      s = plan.pop_front();
      @(negedge clk);
      rdy = (s.ready == 2) ? 1'($urandom_range(0, 1)) : (s.ready == 1);
      if (sel == 0) begin
        bus_a.instruct = instr; bus_a.flags = fl; bus_a.mem_ready = rdy;
        bus_a.run = 1'($urandom_range(0, 1));
      end else begin
        bus_b.instruct = instr; bus_b.flags = fl; bus_b.mem_ready = rdy;
        bus_b.run = 1'($urandom_range(0, 1));
      end
      #1;
      check($sformatf("%s st%0d", name, s.exp.state), sample(sel), s.exp);
    end
  endtask

  task automatic pulse_reset_b();
    @(negedge clk);
    resetn_b = 1'b0;
    #1;
    check("b_async_reset", sample(1), base(3'd0));
    @(negedge clk);
    bus_b.run = 1'b0;
    resetn_b  = 1'b1;
  endtask

  task automatic start_b();
    @(negedge clk);
    bus_b.run = 1'b1;
    #1;
    check("b_idle_run", sample(1), base(3'd0));
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [IW-1:0] instr;
    logic [3:0]    fl;
    obs_t          o;

    resetn_a = 1'b0;
    resetn_b = 1'b0;
    bus_a.run = 1'b0; bus_a.instruct = '0; bus_a.flags = '0; bus_a.mem_ready = 1'b0;
    bus_b.run = 1'b0; bus_b.instruct = '0; bus_b.flags = '0; bus_b.mem_ready = 1'b0;

    #12;
    check("a_reset", sample(0), base(3'd0));
    check("b_reset", sample(1), base(3'd0));
    @(negedge clk);
    resetn_a = 1'b1;
    resetn_b = 1'b1;

    // IDLE holds while run is low
    repeat (2) begin
      @(negedge clk); bus_a.mem_ready = 1'b1; #1;
      check("a_idle_norun", sample(0), base(3'd0));
      check("b_idle_norun", sample(1), base(3'd0));
    end

    @(negedge clk);
    bus_a.run = 1'b1;
    #1;
    check("a_idle_run", sample(0), base(3'd0));

    // ADD with no waits: 1,2,3,5 then back to FETCH
    build_plan(OP_ADD, 2'd0, 4'h0, 0, 0);
    run_plan(0, "add", 16'h0004, 4'h0);
    // LW with three MEM wait cycles
    build_plan(OP_LW, 2'd0, 4'h0, 0, 3);
    run_plan(0, "lw_wait", 16'h0002, 4'h0);
    // BRH on z, taken and not taken
    build_plan(OP_BRH, 2'd1, 4'b0001, 0, 0);
    run_plan(0, "brh_z1", 16'h001F, 4'b0001);
    build_plan(OP_BRH, 2'd1, 4'b1110, 0, 0);
    run_plan(0, "brh_z0", 16'h001F, 4'b1110);
    // Back in FETCH after the branch
    build_plan(OP_LI, 2'd0, 4'h0, 0, 0);
    run_plan(0, "li", 16'h0000, 4'h0);

    // Random instruction stream with random wait states
    for (int n = 0; n < 60; n++) begin
      instr = IW'($urandom);
      fl    = 4'($urandom);
      build_plan(instr[3:0], instr[5:4], fl, $urandom_range(0, 3), $urandom_range(0, 3));
      run_plan(0, $sformatf("rand%0d_op%0d", n, instr[3:0]), instr, fl);
    end

    // --- dut_b: fetch watchdog, four waits then TRAP
    start_b();
    o = base(3'd1); o.mem_req = 1'b1;
    for (int i = 0; i < 4; i++) push(o, 0);
    o = base(3'd7); o.trap = 1'b1;
    for (int i = 0; i < 4; i++) push(o, 2);
    run_plan(1, "wdog_fetch", 16'h0004, 4'h0);
    pulse_reset_b();

    // mem_ready on the limit cycle completes normally, then MEM watchdog
    start_b();
    build_plan(OP_ADD, 2'd0, 4'h0, 3, 0);
    run_plan(1, "wdog_edge", 16'h0004, 4'h0);
    build_plan(OP_LW, 2'd0, 4'h0, 0, 4);
    void'(plan.pop_back());
    void'(plan.pop_back());
    o = base(3'd7); o.trap = 1'b1;
    push(o, 2);
    push(o, 2);
    run_plan(1, "wdog_mem", 16'h0002, 4'h0);
    pulse_reset_b();

    // Opcode 17 traps from DECODE
    start_b();
    o = base(3'd1); o.mem_req = 1'b1; o.ir_load = 1'b1; o.pc_write = 1'b1;
    push(o, 1);
    push(base(3'd2), 2);
    o = base(3'd7); o.trap = 1'b1;
    push(o, 2);
    push(o, 2);
    run_plan(1, "illegal17", 16'h0011, 4'h0);
    pulse_reset_b();

    // Reset mid-wait drops mem_req without a clock edge
    start_b();
    o = base(3'd1); o.mem_req = 1'b1;
    push(o, 0);
    push(o, 0);
    run_plan(1, "midwait", 16'h0004, 4'h0);
    @(negedge clk);
    bus_b.mem_ready = 1'b0;
    #1;
    check("midwait_fetch", sample(1), o);
    #2;
    resetn_b = 1'b0;
    #1;
    check("midwait_reset", sample(1), base(3'd0));
    @(negedge clk);
    bus_b.run = 1'b0;
    resetn_b  = 1'b1;
    #1;
    check("midwait_idle", sample(1), base(3'd0));
    @(negedge clk);
    #1;
    check("midwait_idle_hold", sample(1), base(3'd0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_multicycle_ctrl_unit
